// File: rtl/peri_gpio_tlul.sv
// TL-UL GPIO output register block: DATA_OUT with set/clear/toggle aliases.
// Define GPIO_TLUL_PULSE_EN to add the self-clearing pulse timer.
package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;
endpackage

module peri_gpio_tlul
  import tlul_pkg::*;
#(
  parameter int          NumGpio    = 32,
  parameter logic [31:0] ResetValue = 32'h0,
  parameter int          CntWidth   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  tl_h2d_t            tl_i,
  output tl_d2h_t            tl_o,
  output logic [NumGpio-1:0] gpio_o,
  output logic               pulse_done_o
);

  localparam logic [31:0] GMask = 32'hFFFF_FFFF >> (32 - NumGpio);

  logic [4:0]  off;
  logic [31:0] bm;
  logic [31:0] wd;
  logic        is_get;
  logic        is_put;
  logic        sel_data;
  logic        sel_set;
  logic        sel_clr;
  logic        sel_tog;
  logic        sel_msk;
  logic        sel_cnt;
  logic        err;
  logic        a_ready;
  logic        acc;
  logic        wr;

  logic        rsp_valid;
  logic [2:0]  rsp_opcode;
  logic [1:0]  rsp_size;
  logic [7:0]  rsp_source;
  logic [31:0] rsp_data;
  logic        rsp_error;

  logic [31:0] data_q;
  logic [31:0] data_nxt;
  logic [31:0] rdata;
  logic [31:0] pulse_or;
  logic [31:0] pulse_rd;
  logic [31:0] gpio_full;
  logic        unused_bits;

  assign off    = tl_i.a_address[4:0];
  assign bm     = {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}},
                   {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}};
  assign wd     = tl_i.a_data & bm;
  assign is_get = tl_i.a_opcode == Get;
  assign is_put = tl_i.a_opcode == PutFullData ||
                  tl_i.a_opcode == PutPartialData;

  assign sel_data = off == 5'h00;
  assign sel_set  = off == 5'h04;
  assign sel_clr  = off == 5'h08;
  assign sel_tog  = off == 5'h0C;

  assign err = !(sel_data || sel_set || sel_clr || sel_tog ||
                 sel_msk || sel_cnt) ||
               off[1:0] != 2'b00 ||
               tl_i.a_size == 2'd3 ||
               !(is_get || is_put);

  assign a_ready = !rsp_valid && !rst_i;
  assign acc     = tl_i.a_valid && a_ready;
  assign wr      = acc && is_put && !err;

  always_comb begin
    data_nxt = data_q;
    unique case (1'b1)
      sel_data: data_nxt = (data_q & ~bm) | wd;
      sel_set:  data_nxt = data_q | wd;
      sel_clr:  data_nxt = data_q & ~wd;
      sel_tog:  data_nxt = data_q ^ wd;
      default:  data_nxt = data_q;
    endcase
    data_nxt = data_nxt & GMask;
  end

  assign rdata = sel_data ? data_q : pulse_rd;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= ResetValue & GMask;
    end else if (wr) begin
      data_q <= data_nxt;
    end
  end

`ifdef GPIO_TLUL_PULSE_EN
  logic [31:0]         mask_q;
  logic [CntWidth-1:0] cnt_q;
  logic [31:0]         cnt_wv;
  logic                cnt_we;
  logic                unused_cnt;

  assign sel_msk    = off == 5'h10;
  assign sel_cnt    = off == 5'h14;
  assign cnt_we     = wr && sel_cnt;
  assign cnt_wv     = (32'(cnt_q) & ~bm) | wd;
  assign unused_cnt = ^cnt_wv;

  // A counter write wins over the decrement of the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr && sel_msk) begin
        mask_q <= ((mask_q & ~bm) | wd) & GMask;
      end
      if (cnt_we) begin
        cnt_q <= cnt_wv[CntWidth-1:0];
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CntWidth'(1);
      end
    end
  end

  assign pulse_or     = (cnt_q != '0) ? mask_q : '0;
  assign pulse_done_o = (cnt_q == CntWidth'(1)) && !cnt_we;
  assign pulse_rd     = sel_msk ? mask_q :
                        sel_cnt ? 32'(cnt_q) : '0;
`else
  assign sel_msk      = 1'b0;
  assign sel_cnt      = 1'b0;
  assign pulse_or     = '0;
  assign pulse_rd     = '0;
  assign pulse_done_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid  <= 1'b0;
      rsp_opcode <= '0;
      rsp_size   <= '0;
      rsp_source <= '0;
      rsp_data   <= '0;
      rsp_error  <= 1'b0;
    end else if (acc) begin
      rsp_valid  <= 1'b1;
      rsp_opcode <= is_get ? AccessAckData : AccessAck;
      rsp_size   <= tl_i.a_size;
      rsp_source <= tl_i.a_source;
      rsp_data   <= (is_get && !err) ? rdata : '0;
      rsp_error  <= err;
    end else if (rsp_valid && tl_i.d_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = rsp_valid;
    tl_o.d_opcode = rsp_opcode;
    tl_o.d_param  = 3'h0;
    tl_o.d_size   = rsp_size;
    tl_o.d_source = rsp_source;
    tl_o.d_sink   = 1'b0;
    tl_o.d_data   = rsp_data;
    tl_o.d_error  = rsp_error;
    tl_o.a_ready  = a_ready;
  end

  assign gpio_full   = data_q | pulse_or;
  assign gpio_o      = gpio_full[NumGpio-1:0];
  assign unused_bits = ^{tl_i.a_param, tl_i.a_address[31:5], gpio_full};

endmodule
